// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry computes
// {cout,sum} = a + b + cin one bit per clock.
// Latency: done pulses WIDTH edges after the edge that accepts start.
// Backpressure: start is honoured only in IDLE. A request in RUN or DONE is dropped, not queued.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, a, b, cin request and operands, captured on the accepting edge
//   busy, done       busy is high while bits are processed; done is a 1-cycle result pulse
//   sum, cout        registered result, updated only when done rises
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic bit_sum;
    logic bit_carry;
    logic last_bit;
    logic accept;

    // Single full-adder cell working on the LSBs of the operand shifters.
    assign bit_sum   = op_a[0] ^ op_b[0] ^ carry;
    assign bit_carry = (op_a[0] & op_b[0]) | (op_b[0] & carry) | (carry & op_a[0]);
    assign last_bit  = (cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            psum  <= '0;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at the LSB.
            psum  <= {bit_sum, psum[WIDTH-1:1]};
            carry <= bit_carry;
            // Hold the counter on the final bit so it never wraps within an operation.
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
            if (last_bit) begin
                sum  <= {bit_sum, psum[WIDTH-1:1]};
                cout <= bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk;
    logic rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );
    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    int total = 0;
    int bad   = 0;
    int q8[$];
    int q2[$];
    int q16[$];
    logic [31:0] hold [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] res_of(input int k);
        case (k)
            0:       res_of = 32'({cout8, sum8});
            1:       res_of = 32'({cout2, sum2});
            default: res_of = 32'({cout16, sum16});
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0:       busy_of = busy8;
            1:       busy_of = busy2;
            default: busy_of = busy16;
        endcase
    endfunction

    function automatic logic done_of(input int k);
        case (k)
            0:       done_of = done8;
            1:       done_of = done2;
            default: done_of = done16;
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       qsize = q8.size();
            1:       qsize = q2.size();
            default: qsize = q16.size();
        endcase
    endfunction

    function automatic int pop_exp(input int k);
        case (k)
            0:       pop_exp = q8.pop_front();
            1:       pop_exp = q2.pop_front();
            default: pop_exp = q16.pop_front();
        endcase
    endfunction

    task automatic push_exp(input int k, input int v);
        case (k)
            0:       q8.push_back(v);
            1:       q2.push_back(v);
            default: q16.push_back(v);
        endcase
    endtask

    task automatic set_in(input int k, input logic st, input int ra, input int rb, input int rc);
        case (k)
            0:       begin start8  = st; a8  = ra[7:0];  b8  = rb[7:0];  cin8  = rc[0]; end
            1:       begin start2  = st; a2  = ra[1:0];  b2  = rb[1:0];  cin2  = rc[0]; end
            default: begin start16 = st; a16 = ra[15:0]; b16 = rb[15:0]; cin16 = rc[0]; end
        endcase
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks that the
    // result registers hold steady at all other times.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                hold[k] = 32'd0;
            end else begin
                chk($sformatf("busy_done_excl_w%0d", k), 32'(busy_of(k) & done_of(k)), 32'd0);
                if (done_of(k) === 1'b1) begin
                    if (qsize(k) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done dut%0d: done with no pending op, result 0x%0h at t=%0t",
                                 k, res_of(k), $time);
                    end else begin
                        chk($sformatf("result_dut%0d", k), res_of(k), 32'(pop_exp(k)));
                    end
                    hold[k] = res_of(k);
                end else begin
                    chk($sformatf("hold_dut%0d", k), res_of(k), hold[k]);
                end
            end
        end
    end

    task automatic wait_idle(input int k);
        int g = 0;
        while ((busy_of(k) !== 1'b0 || done_of(k) !== 1'b0) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk($sformatf("idle_dut%0d", k), {30'd0, busy_of(k), done_of(k)}, 32'd0);
    endtask

    task automatic drain(input int k);
        int g = 0;
        while (qsize(k) != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk($sformatf("drain_dut%0d", k), 32'(qsize(k)), 32'd0);
    endtask

    // One 8-bit operation with latency and busy-length checks; operands are
    // scrambled right after acceptance to show they are not re-sampled.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int lat = 0;
        int bcnt = 0;
        wait_idle(0);
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        push_exp(0, int'(ta) + int'(tb) + int'(tc));
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency8", 32'(lat), 32'd8);
        chk("busy_cycles8", 32'(bcnt), 32'd8);
        @(posedge clk); #1;
        chk("done_one_cycle8", {30'd0, busy8, done8}, 32'd0);
    endtask

    // Holds start high with fresh random operands every cycle; every rising
    // busy marks an acceptance using the operands present at that edge.
    task automatic b2b(input int k, input int w, input int nops);
        int cyc = 0;
        int last = -1;
        int n = 0;
        int guard = 0;
        int m, ra, rb, rc;
        logic pb;
        m = (1 << w) - 1;
        wait_idle(k);
        pb = busy_of(k);
        while (n < nops && guard < nops * (w + 2) + 20) begin
            ra = (n == 0) ? m : (int'($urandom) & m);
            rb = (n == 0) ? m : (int'($urandom) & m);
            rc = (n == 0) ? 1 : (int'($urandom) & 1);
            set_in(k, 1'b1, ra, rb, rc);
            @(posedge clk); #1;
            cyc++;
            guard++;
            if (busy_of(k) === 1'b1 && pb !== 1'b1) begin
                push_exp(k, ra + rb + rc);
                if (last >= 0) chk($sformatf("accept_spacing_w%0d", w), 32'(cyc - last), 32'(w + 2));
                last = cyc;
                n++;
            end
            pb = busy_of(k);
        end
        chk($sformatf("b2b_count_w%0d", w), 32'(n), 32'(nops));
        set_in(k, 1'b0, 0, 0, 0);
        drain(k);
    endtask

    initial begin
        int g;
        rst = 1'b0;
        set_in(0, 1'b0, 0, 0, 0);
        set_in(1, 1'b0, 0, 0, 0);
        set_in(2, 1'b0, 0, 0, 0);

        // Asynchronous reset between clock edges.
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), 32'(busy_of(k)), 32'd0);
            chk($sformatf("rst_done%0d", k), 32'(done_of(k)), 32'd0);
            chk($sformatf("rst_result%0d", k), res_of(k), 32'd0);
        end
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Directed 8-bit cases.
        op8(8'h00, 8'h00, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hA5, 8'h5A, 1'b1);

        // start and operand changes during RUN and DONE must be ignored.
        wait_idle(0);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        push_exp(0, 32'h46);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        g = 0;
        while (done8 !== 1'b1 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("ignored_done_seen", 32'(done8), 32'd1);
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("no_relaunch_busy", 32'(busy8), 32'd0);
            @(posedge clk); #1;
        end
        chk("ignored_result", res_of(0), 32'h46);

        // Reset in the middle of RUN aborts the operation.
        wait_idle(0);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        push_exp(0, 32'h100);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        q8.delete();
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_result", res_of(0), 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("midrst_idle", {30'd0, busy8, done8}, 32'd0);
        end
        op8(8'h80, 8'h80, 1'b0);

        // Back-to-back acceptance spacing and random operands.
        b2b(0, 8, 8);
        for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
        drain(0);
        b2b(1, 2, 1000);
        b2b(2, 16, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
